// File: rtl/block_mover.sv
// block_mover: sweeps the active block across its row, bouncing off
// the playfield edges, and hands each new position to the renderer.
module block_mover #(
  parameter int X_W    = 8,
  parameter int Y_W    = 7,
  parameter int DIFF_W = 3,
  parameter int X_MIN  = 0,
  parameter int X_MAX  = 144,
  parameter int ROWS   = 7
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              start,
  input  logic              frame_tick,
  input  logic              drop,
  input  logic [DIFF_W-1:0] difficulty,
  input  logic              new_direction,
  input  logic [X_W-1:0]    new_x_position,
  input  logic [Y_W-1:0]    new_y_position,
  input  logic              draw_ack,
  output logic [X_W-1:0]    x_pos,
  output logic [Y_W-1:0]    y_pos,
  output logic              direction,
  output logic              draw_req,
  output logic              inc_row,
  output logic [X_W-1:0]    landed_x,
  output logic              done
);

  localparam int RW = $clog2(ROWS + 1);
  localparam logic [X_W-1:0] XMIN = X_W'(X_MIN);
  localparam logic [X_W-1:0] XMAX = X_W'(X_MAX);
  localparam logic [RW-1:0]  LAST = RW'(ROWS - 1);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    DRAW,
    MOVE,
    LAND,
    DONE
  } state_t;

  state_t state, state_n;

  logic [X_W-1:0]    x_q, x_n;
  logic [Y_W-1:0]    y_q, y_n;
  logic              dir_q, dir_n;
  logic [DIFF_W-1:0] spd_q, spd_n;
  logic [DIFF_W-1:0] cnt_q, cnt_n;
  logic [RW-1:0]     row_q, row_n;
  logic              pend_q, pend_n;
  logic [X_W-1:0]    land_q, land_n;
  logic              done_q, done_n;

  logic [X_W-1:0]    x_step;
  logic              dir_step;
  logic [X_W-1:0]    x_load;
  logic [DIFF_W:0]   cnt_inc;

  // Next position on a step, reflecting at either edge
  always_comb begin
    x_step   = x_q;
    dir_step = dir_q;
    if (dir_q && x_q >= XMAX) begin
      x_step   = XMAX - X_W'(1);
      dir_step = 1'b0;
    end else if (!dir_q && x_q == XMIN) begin
      x_step   = XMIN + X_W'(1);
      dir_step = 1'b1;
    end else if (dir_q) begin
      x_step = x_q + X_W'(1);
    end else begin
      x_step = x_q - X_W'(1);
    end
  end

  assign x_load  = (new_x_position > XMAX)
                 ? XMAX : new_x_position;
  assign cnt_inc = {1'b0, cnt_q} + (DIFF_W+1)'(1);

  always_comb begin
    state_n = state;
    x_n     = x_q;
    y_n     = y_q;
    dir_n   = dir_q;
    spd_n   = spd_q;
    cnt_n   = cnt_q;
    row_n   = row_q;
    pend_n  = pend_q;
    land_n  = land_q;
    done_n  = done_q;
    unique case (state)
      IDLE, DONE: begin
        if (start) begin
          state_n = LOAD;
          row_n   = '0;
          done_n  = 1'b0;
          pend_n  = 1'b0;
        end
      end
      LOAD: begin
        x_n   = x_load;
        y_n   = new_y_position;
        dir_n = new_direction;
        spd_n = (difficulty == '0)
              ? DIFF_W'(1) : difficulty;
        cnt_n = '0;
        if (drop) pend_n = 1'b1;
        state_n = DRAW;
      end
      DRAW: begin
        if (drop) pend_n = 1'b1;
        if (draw_ack) state_n = MOVE;
      end
      MOVE: begin
        // A drop beats a same-cycle frame tick
        if (drop || pend_q) begin
          state_n = LAND;
        end else if (frame_tick) begin
          if (cnt_inc < {1'b0, spd_q}) begin
            cnt_n = cnt_inc[DIFF_W-1:0];
          end else begin
            cnt_n   = '0;
            x_n     = x_step;
            dir_n   = dir_step;
            state_n = DRAW;
          end
        end
      end
      LAND: begin
        land_n = x_q;
        pend_n = 1'b0;
        row_n  = row_q + RW'(1);
        if (row_q == LAST) begin
          state_n = DONE;
          done_n  = 1'b1;
        end else begin
          state_n = LOAD;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state  <= IDLE;
      x_q    <= '0;
      y_q    <= '0;
      dir_q  <= 1'b1;
      spd_q  <= DIFF_W'(1);
      cnt_q  <= '0;
      row_q  <= '0;
      pend_q <= 1'b0;
      land_q <= '0;
      done_q <= 1'b0;
    end else begin
      state  <= state_n;
      x_q    <= x_n;
      y_q    <= y_n;
      dir_q  <= dir_n;
      spd_q  <= spd_n;
      cnt_q  <= cnt_n;
      row_q  <= row_n;
      pend_q <= pend_n;
      land_q <= land_n;
      done_q <= done_n;
    end
  end

  assign x_pos     = x_q;
  assign y_pos     = y_q;
  assign direction = dir_q;
  assign draw_req  = (state == DRAW);
  assign inc_row   = (state == LAND);
  assign landed_x  = land_q;
  assign done      = done_q;

endmodule

// File: tb/tb_block_mover.sv
// tb_block_mover: directed plus randomized rows checked against
// a simple position/bounce model of the playfield.
module tb_block_mover;

  localparam int XMAX = 144;
  localparam int ROWS = 7;

  logic       clk = 1'b0;
  logic       resetn;
  logic       start;
  logic       frame_tick;
  logic       drop;
  logic [2:0] difficulty;
  logic       new_direction;
  logic [7:0] new_x_position;
  logic [6:0] new_y_position;
  logic       draw_ack;
  logic [7:0] x_pos;
  logic [6:0] y_pos;
  logic       direction;
  logic       draw_req;
  logic       inc_row;
  logic [7:0] landed_x;
  logic       done;

  always #5 clk = ~clk;

  block_mover dut (
    .clk(clk),
    .resetn(resetn),
    .start(start),
    .frame_tick(frame_tick),
    .drop(drop),
    .difficulty(difficulty),
    .new_direction(new_direction),
    .new_x_position(new_x_position),
    .new_y_position(new_y_position),
    .draw_ack(draw_ack),
    .x_pos(x_pos),
    .y_pos(y_pos),
    .direction(direction),
    .draw_req(draw_req),
    .inc_row(inc_row),
    .landed_x(landed_x),
    .done(done)
  );

  int checks = 0;
  int passed = 0;
  int m_x, m_y, m_dir, m_spd, m_cnt;
  int m_rows, m_landed;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0d expected=%0d",
                tag, obs, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_row(input int x, input int y,
                         input int d, input int df);
    new_x_position = 8'(x);
    new_y_position = 7'(y);
    new_direction  = d[0];
    difficulty     = 3'(df);
    m_x   = x;
    m_y   = y;
    m_dir = d;
    m_spd = (df == 0) ? 1 : df;
    m_cnt = 0;
  endtask

  task automatic model_step();
    if (m_dir == 1 && m_x == XMAX) begin
      m_dir = 0;
      m_x   = XMAX - 1;
    end else if (m_dir == 0 && m_x == 0) begin
      m_dir = 1;
      m_x   = 1;
    end else begin
      m_x = m_x + (m_dir == 1 ? 1 : -1);
    end
  endtask

  task automatic chk_draw(input string tag);
    chk({tag, "_req"}, draw_req, 1);
    chk({tag, "_x"}, x_pos, m_x);
    chk({tag, "_y"}, y_pos, m_y);
    chk({tag, "_dir"}, direction, m_dir);
  endtask

  task automatic do_start();
    start = 1'b1;
    cyc();
    start = 1'b0;
    chk("load_req", draw_req, 0);
    chk("load_done", done, 0);
    cyc();
    chk_draw("draw0");
  endtask

  task automatic do_ack(input int n, input bit noisy);
    for (int i = 0; i < n; i++) begin
      frame_tick = noisy ? 1'($urandom_range(0, 1)) : 1'b0;
      cyc();
      frame_tick = 1'b0;
      chk("hold_req", draw_req, 1);
      chk("hold_x", x_pos, m_x);
    end
    draw_ack = 1'b1;
    cyc();
    draw_ack = 1'b0;
    chk("ack_req", draw_req, 0);
  endtask

  task automatic gap(input int n);
    for (int i = 0; i < n; i++) begin
      cyc();
      chk("idle_req", draw_req, 0);
    end
  endtask

  task automatic do_tick();
    frame_tick = 1'b1;
    cyc();
    frame_tick = 1'b0;
    if (m_cnt + 1 < m_spd) begin
      m_cnt++;
      chk("tick_req", draw_req, 0);
      chk("tick_x", x_pos, m_x);
    end else begin
      m_cnt = 0;
      model_step();
      chk_draw("step");
    end
  endtask

  task automatic land_seq(input int nx, input int ny,
                          input int nd, input int ndf);
    chk("land_inc", inc_row, 1);
    chk("land_done", done, 0);
    m_landed = m_x;
    set_row(nx, ny, nd, ndf);
    cyc();
    m_rows++;
    chk("inc_pulse", inc_row, 0);
    chk("landed_x", landed_x, m_landed);
    if (m_rows == ROWS) begin
      chk("done_set", done, 1);
      chk("done_req", draw_req, 0);
    end else begin
      chk("done_low", done, 0);
      chk("reload_req", draw_req, 0);
      cyc();
      chk_draw("draw_row");
    end
  endtask

  task automatic land_rand();
    land_seq($urandom_range(0, XMAX), $urandom_range(0, 127),
             $urandom_range(0, 1), $urandom_range(0, 7));
  endtask

  task automatic drop_move(input bit with_tick);
    drop       = 1'b1;
    frame_tick = with_tick;
    cyc();
    drop       = 1'b0;
    frame_tick = 1'b0;
  endtask

  task automatic random_row();
    int nsteps;
    nsteps = $urandom_range(0, 4);
    if ($urandom_range(0, 3) == 0) begin
      drop = 1'b1;
      cyc();
      drop = 1'b0;
      chk("pend_req", draw_req, 1);
      do_ack($urandom_range(0, 4), 1'b1);
      cyc();
      land_rand();
    end else begin
      for (int s = 0; s < nsteps; s++) begin
        do_ack($urandom_range(0, 3), 1'b1);
        for (int k = 0; k < m_spd; k++) begin
          gap($urandom_range(0, 2));
          do_tick();
        end
      end
      do_ack($urandom_range(0, 3), 1'b1);
      gap($urandom_range(0, 2));
      drop_move(1'($urandom_range(0, 1)));
      land_rand();
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    resetn     = 1'b0;
    start      = 1'b0;
    frame_tick = 1'b0;
    drop       = 1'b0;
    draw_ack   = 1'b0;
    m_rows     = 0;
    set_row(0, 104, 1, 4);
    @(negedge clk);
    @(negedge clk);
    chk("rst_x", x_pos, 0);
    chk("rst_y", y_pos, 0);
    chk("rst_dir", direction, 1);
    chk("rst_req", draw_req, 0);
    chk("rst_inc", inc_row, 0);
    chk("rst_land", landed_x, 0);
    chk("rst_done", done, 0);
    resetn = 1'b1;
    cyc();
    drop       = 1'b1;
    frame_tick = 1'b1;
    cyc();
    drop       = 1'b0;
    frame_tick = 1'b0;
    chk("idle_drop_req", draw_req, 0);
    chk("idle_drop_inc", inc_row, 0);

    do_start();
    do_ack(0, 1'b0);
    repeat (4) do_tick();
    chk("t1_x1", x_pos, 1);
    do_ack(0, 1'b0);
    drop_move(1'b0);
    land_seq(143, 90, 1, 1);

    repeat (3) begin
      do_ack(0, 1'b0);
      do_tick();
    end
    chk("t2_x", x_pos, 142);
    chk("t2_dir", direction, 0);
    do_ack(0, 1'b0);
    drop_move(1'b0);
    land_seq(1, 80, 0, 1);

    repeat (3) begin
      do_ack(0, 1'b0);
      do_tick();
    end
    chk("t2m_x", x_pos, 2);
    chk("t2m_dir", direction, 1);
    do_ack(0, 1'b0);
    drop_move(1'b0);
    land_seq(48, 70, 1, 1);

    repeat (2) begin
      do_ack(0, 1'b0);
      do_tick();
    end
    do_ack(0, 1'b0);
    chk("t3_pre_x", x_pos, 50);
    drop_move(1'b1);
    land_seq(20, 60, 0, 3);
    chk("t3_landed", landed_x, 50);

    drop = 1'b1;
    cyc();
    drop = 1'b0;
    do_ack(4, 1'b0);
    chk("t4_move_inc", inc_row, 0);
    cyc();
    land_seq(100, 50, 1, 0);
    chk("t4_landed", landed_x, 20);

    repeat (2) random_row();

    drop       = 1'b1;
    frame_tick = 1'b1;
    cyc();
    drop       = 1'b0;
    frame_tick = 1'b0;
    cyc();
    chk("t5_done", done, 1);
    chk("t5_inc", inc_row, 0);
    chk("t5_req", draw_req, 0);
    chk("t5_x", x_pos, m_landed);

    m_rows = 0;
    do_start();
    repeat (ROWS) random_row();
    chk("g2_done", done, 1);

    m_rows = 0;
    set_row(77, 33, 0, 2);
    do_start();
    #2;
    resetn = 1'b0;
    #1;
    chk("t6_req", draw_req, 0);
    chk("t6_x", x_pos, 0);
    chk("t6_y", y_pos, 0);
    chk("t6_dir", direction, 1);
    chk("t6_land", landed_x, 0);
    chk("t6_done", done, 0);
    chk("t6_inc", inc_row, 0);
    @(negedge clk);
    resetn = 1'b1;
    cyc();
    chk("t6_idle_req", draw_req, 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
